// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control FSM and its FIFO/arbiter neighbours.
// Holds the one-hot state encoding, its width and small state-class helpers.
// No ports; import with `import flow_ctrl_pkg::*;`.
package flow_ctrl_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    // States in which FIFO error pulses are captured into the sticky flags.
    function automatic logic captures_errors(input state_t s);
        return (s == ST_IDLE) || (s == ST_ACTIVE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/umbral_hyst.sv
// Purpose : per-FIFO pause hysteresis (set at/above high threshold, clear at/below low).
// Latency : one cycle from count/threshold to o_pause.
// Backpressure: o_pause is the backpressure bit; forces override the hysteresis.
// Ports: clk, reset (async active-low), i_count, i_umbral_sup, i_umbral_inf,
//        i_force_clr, i_force_set -> o_pause (registered).
module umbral_hyst #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_count,
    input  logic [CNT_W-1:0] i_umbral_sup,
    input  logic [CNT_W-1:0] i_umbral_inf,
    input  logic             i_force_clr,
    input  logic             i_force_set,
    output logic             o_pause
);

    logic r_pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pause <= 1'b0;
        end else if (i_force_set) begin
            r_pause <= 1'b1;
        end else if (i_force_clr) begin
            r_pause <= 1'b0;
        end else if (i_count >= i_umbral_sup) begin
            // Checked first so that inverted thresholds resolve to "set".
            r_pause <= 1'b1;
        end else if (i_count <= i_umbral_inf) begin
            r_pause <= 1'b0;
        end
    end

    assign o_pause = r_pause;

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Purpose : supervises NUM_FIFOS FIFOs: one-hot FSM, threshold latch, pause and sticky errors.
// Latency : all outputs registered; one cycle from inputs to state/pause/error_out.
// Backpressure: pause[i] per FIFO via hysteresis; all paused in ERROR, none in RESET/INIT.
// Ports: clk, reset (async active-low), init, umbral_alto/bajo, fifo_count, empties,
//        fifo_err -> umbral_superior/inferior, state, idle_out, pause, error_out.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = 8,
    parameter int CNT_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [CNT_W-1:0]           umbral_alto,
    input  logic [CNT_W-1:0]           umbral_bajo,
    input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
    input  logic [NUM_FIFOS-1:0]       empties,
    input  logic [NUM_FIFOS-1:0]       fifo_err,
    output logic [CNT_W-1:0]           umbral_superior,
    output logic [CNT_W-1:0]           umbral_inferior,
    output logic [STATE_W-1:0]         state,
    output logic                       idle_out,
    output logic [NUM_FIFOS-1:0]       pause,
    output logic [NUM_FIFOS-1:0]       error_out
);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_idle;
    logic [CNT_W-1:0]     r_umbral_sup;
    logic [CNT_W-1:0]     r_umbral_inf;
    logic [NUM_FIFOS-1:0] r_error;
    logic                 w_force_clr;
    logic                 w_force_set;

    always_comb begin
        w_next_state = ST_RESET;
        if (init) begin
            w_next_state = ST_INIT;
        end else begin
            unique case (r_state)
                ST_RESET:  w_next_state = ST_INIT;
                ST_INIT:   w_next_state = ST_IDLE;
                ST_IDLE,
                ST_ACTIVE: begin
                    if (|fifo_err)
                        w_next_state = ST_ERROR;
                    else if (&empties)
                        w_next_state = ST_IDLE;
                    else
                        w_next_state = ST_ACTIVE;
                end
                ST_ERROR:  w_next_state = ST_ERROR;
                default:   w_next_state = ST_RESET;
            endcase
        end
    end

    // Forces follow the state being entered so pause lines up with state.
    assign w_force_clr = (w_next_state == ST_RESET) || (w_next_state == ST_INIT);
    assign w_force_set = (w_next_state == ST_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RESET;
            r_idle       <= 1'b0;
            r_umbral_sup <= '0;
            r_umbral_inf <= '0;
            r_error      <= '0;
        end else begin
            r_state <= w_next_state;
            r_idle  <= (w_next_state == ST_IDLE);

            if (r_state == ST_INIT) begin
                r_umbral_sup <= umbral_alto;
                r_umbral_inf <= umbral_bajo;
            end

            // Clear wins: a pulse arriving with init is dropped.
            if (init || (r_state == ST_INIT))
                r_error <= '0;
            else if (captures_errors(r_state))
                r_error <= r_error | fifo_err;
        end
    end

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_hyst
        umbral_hyst #(
            .CNT_W (CNT_W)
        ) u_hyst (
            .clk          (clk),
            .reset        (reset),
            .i_count      (fifo_count[g*CNT_W +: CNT_W]),
            .i_umbral_sup (r_umbral_sup),
            .i_umbral_inf (r_umbral_inf),
            .i_force_clr  (w_force_clr),
            .i_force_set  (w_force_set),
            .o_pause      (pause[g])
        );
    end

    assign state           = r_state;
    assign idle_out        = r_idle;
    assign umbral_superior = r_umbral_sup;
    assign umbral_inferior = r_umbral_inf;
    assign error_out       = r_error;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
module tb_flow_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUT A: default 8 x 3-bit ----------------
    logic        rst_a = 1'b1;
    logic        init_a = 1'b0;
    logic [2:0]  alto_a = 3'd6, bajo_a = 3'd2;
    logic [23:0] cnt_a = '0;
    logic [7:0]  emp_a = 8'hFF, err_a = 8'h00;
    logic [2:0]  sup_a, inf_a;
    logic [4:0]  st_a;
    logic        idle_a;
    logic [7:0]  pause_a, eout_a;

    flow_ctrl_fsm u_dut_a (
        .clk(clk), .reset(rst_a), .init(init_a),
        .umbral_alto(alto_a), .umbral_bajo(bajo_a),
        .fifo_count(cnt_a), .empties(emp_a), .fifo_err(err_a),
        .umbral_superior(sup_a), .umbral_inferior(inf_a),
        .state(st_a), .idle_out(idle_a), .pause(pause_a), .error_out(eout_a)
    );

    // ---------------- DUT B: 4 x 5-bit ----------------
    logic        rst_b = 1'b1;
    logic        init_b = 1'b0;
    logic [4:0]  alto_b = 5'd20, bajo_b = 5'd10;
    logic [19:0] cnt_b = '0;
    logic [3:0]  emp_b = 4'hF, err_b = 4'h0;
    logic [4:0]  sup_b, inf_b;
    logic [4:0]  st_b;
    logic        idle_b;
    logic [3:0]  pause_b, eout_b;

    flow_ctrl_fsm #(.NUM_FIFOS(4), .CNT_W(5)) u_dut_b (
        .clk(clk), .reset(rst_b), .init(init_b),
        .umbral_alto(alto_b), .umbral_bajo(bajo_b),
        .fifo_count(cnt_b), .empties(emp_b), .fifo_err(err_b),
        .umbral_superior(sup_b), .umbral_inferior(inf_b),
        .state(st_b), .idle_out(idle_b), .pause(pause_b), .error_out(eout_b)
    );

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    // Hysteresis vectors: count applied, pause[0] expected after the edge.
    logic [2:0] seq_a_cnt [6] = '{3'd5, 3'd6, 3'd4, 3'd3, 3'd2, 3'd1};
    logic       seq_a_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] seq_b_cnt [4] = '{5'd19, 5'd20, 5'd15, 5'd10};
    logic       seq_b_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        // Asynchronous reset with no clock edge yet.
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #2;
        chk("rst_state", 32'(st_a), 32'(S_RESET));
        chk("rst_idle", 32'(idle_a), 32'd0);
        chk("rst_pause", 32'(pause_a), 32'd0);
        chk("rst_err", 32'(eout_a), 32'd0);
        chk("rst_sup", 32'(sup_a), 32'd0);
        chk("rst_inf", 32'(inf_a), 32'd0);

        @(negedge clk);
        rst_a = 1'b1;
        step();
        chk("boot_e1_state", 32'(st_a), 32'(S_INIT));
        chk("boot_e1_idle", 32'(idle_a), 32'd0);
        step();
        chk("boot_e2_state", 32'(st_a), 32'(S_IDLE));
        chk("boot_e2_idle", 32'(idle_a), 32'd1);
        chk("boot_sup", 32'(sup_a), 32'd6);
        chk("boot_inf", 32'(inf_a), 32'd2);
        step();
        chk("boot_e3_state", 32'(st_a), 32'(S_IDLE));
        chk("boot_e3_idle", 32'(idle_a), 32'd1);
        chk("idle_pause", 32'(pause_a), 32'd0);

        // IDLE <-> ACTIVE on empties.
        emp_a = 8'hFE;
        step();
        chk("to_active", 32'(st_a), 32'(S_ACTIVE));
        chk("active_idle", 32'(idle_a), 32'd0);
        emp_a = 8'hFF;
        step();
        chk("to_idle", 32'(st_a), 32'(S_IDLE));
        chk("back_idle", 32'(idle_a), 32'd1);

        // Hysteresis 6/2 on FIFO0 while ACTIVE.
        emp_a = 8'hFE;
        for (int i = 0; i < 6; i++) begin
            cnt_a = {21'd0, seq_a_cnt[i]};
            step();
            chk($sformatf("hyst_a_%0d", i), 32'(pause_a[0]), 32'(seq_a_exp[i]));
        end
        chk("hyst_a_state", 32'(st_a), 32'(S_ACTIVE));

        // Error pulse on FIFO3.
        err_a = 8'h08;
        step();
        chk("err_state", 32'(st_a), 32'(S_ERROR));
        chk("err_pause", 32'(pause_a), 32'hFF);
        chk("err_flags", 32'(eout_a), 32'h08);
        // ERROR ignores empties, still captures further error pulses.
        err_a = 8'h10;
        emp_a = 8'hFF;
        step();
        chk("err_hold_state", 32'(st_a), 32'(S_ERROR));
        chk("err_hold_pause", 32'(pause_a), 32'hFF);
        chk("err_sticky", 32'(eout_a), 32'h18);
        err_a = 8'h00;
        step();
        chk("err_hold2", 32'(st_a), 32'(S_ERROR));
        chk("err_sticky2", 32'(eout_a), 32'h18);

        // init leaves ERROR; simultaneous error pulse must be dropped.
        init_a = 1'b1;
        err_a = 8'h01;
        step();
        chk("init_state", 32'(st_a), 32'(S_INIT));
        chk("init_err_clr", 32'(eout_a), 32'd0);
        chk("init_pause", 32'(pause_a), 32'd0);
        chk("init_sup_hold", 32'(sup_a), 32'd6);

        // Inverted thresholds 2/5: set must win.
        err_a = 8'h00;
        alto_a = 3'd2;
        bajo_a = 3'd5;
        step();
        chk("inv_sup", 32'(sup_a), 32'd2);
        chk("inv_inf", 32'(inf_a), 32'd5);
        chk("inv_init_state", 32'(st_a), 32'(S_INIT));
        init_a = 1'b0;
        emp_a = 8'hFE;
        cnt_a = {21'd0, 3'd3};
        step();
        chk("inv_idle_state", 32'(st_a), 32'(S_IDLE));
        chk("inv_pause", 32'(pause_a), 32'h01);
        alto_a = 3'd7;
        step();
        chk("inv_active", 32'(st_a), 32'(S_ACTIVE));
        chk("inv_pause2", 32'(pause_a), 32'h01);
        chk("thr_hold", 32'(sup_a), 32'd2);

        // Asynchronous reset mid-ACTIVE, away from any edge.
        #2;
        rst_a = 1'b0;
        #1;
        chk("mid_rst_state", 32'(st_a), 32'(S_RESET));
        chk("mid_rst_pause", 32'(pause_a), 32'd0);
        chk("mid_rst_idle", 32'(idle_a), 32'd0);
        chk("mid_rst_err", 32'(eout_a), 32'd0);
        chk("mid_rst_sup", 32'(sup_a), 32'd0);
        chk("mid_rst_inf", 32'(inf_a), 32'd0);

        // DUT B: 4 x 5-bit, thresholds 20/10.
        @(negedge clk);
        rst_b = 1'b1;
        step();
        step();
        chk("b_state", 32'(st_b), 32'(S_IDLE));
        chk("b_sup", 32'(sup_b), 32'd20);
        chk("b_inf", 32'(inf_b), 32'd10);
        emp_b = 4'hE;
        cnt_b = '0;
        step();
        chk("b_pause_clr", 32'(pause_b), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cnt_b = {15'd0, seq_b_cnt[i]};
            step();
            chk($sformatf("hyst_b_%0d", i), 32'(pause_b[0]), 32'(seq_b_exp[i]));
        end
        chk("b_active", 32'(st_b), 32'(S_ACTIVE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
